alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Sequencer that drives the 8-bit ALU: accepts one instruction over a valid/ready
//  handshake, reads two operands from a small internal register file, presents
//  A/B/sel/c_in to alu8, captures Y/C, writes the result back and updates a carry flag.
//  Sits between the instruction source and alu8. The ALU itself stays combinational.
// PARAMETERS
//  NREGS   4   register file depth (power of 2, >=2); AW = $clog2(NREGS)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  instr_valid  in   1   instruction present
//  instr_ready  out  1   controller can accept (high only in IDLE)
//  instr_op     in   4   opcode: ADD 0000, SUB 0001, AND 0010, OR 0011, NAND 0100,
//                        NOR 0101, NOT 0110, XOR 0111, XNOR 1000; 1001-1111 illegal
//  instr_dst    in   AW  destination register
//  instr_srca   in   AW  operand A register
//  instr_srcb   in   AW  operand B register (ignored for NOT)
//  instr_usec   in   1   ADD only: c_in = carry_flag (else c_in = 0)
//  load_en      in   1   host write into register file
//  load_addr    in   AW  host write address
//  load_data    in   8   host write data
//  alu_a        out  8   to alu8 A
//  alu_b        out  8   to alu8 B
//  alu_sel      out  4   to alu8 sel
//  alu_c_in     out  1   to alu8 c_in
//  alu_y        in   8   from alu8 Y
//  alu_c        in   1   from alu8 C
//  wb_valid     out  1   one-cycle pulse: result written
//  wb_dst       out  AW  register written
//  wb_data      out  8   value written
//  carry_flag   out  1   registered carry
//  illegal_op   out  1   pulses with wb_valid when opcode was illegal
// BEHAVIOUR
//  - Reset: state IDLE, all regs = 0, carry_flag 0, wb_valid 0, illegal_op 0,
//    wb_dst/wb_data 0, alu_a/alu_b/alu_sel/alu_c_in 0, instr_ready 1 after release.
//  - FSM IDLE -> EXEC -> WB -> IDLE. Accept when instr_valid & instr_ready in IDLE.
//  - Accept edge (cycle 0): latch op/dst, read regs[srca], regs[srcb] into operand
//    regs; c_in latched = instr_usec & (op==ADD) ? carry_flag : 0.
//  - EXEC (cycle 1): alu_* driven from latched operands; alu_y/alu_c sampled at end.
//  - WB (cycle 2): regs[dst] <= captured Y; wb_valid=1, wb_dst, wb_data valid.
//    carry_flag updated only for ADD/SUB (SUB: alu_c=1 means no borrow); unchanged
//    for logic ops. Illegal op: result forced 0, carry unchanged, illegal_op=1.
//  - Throughput one instruction per 3 cycles; instr_ready low in EXEC and WB.
//  - alu_* outputs hold last values outside EXEC (no glitching to 0).
//  - Load port active in every state. Load and accept same cycle, same address:
//    operand gets OLD value. Load and WB same cycle, same address: WB wins.
//  - srca==srcb legal; dst may equal a source (read happens at accept, no hazard).
//  - Reset mid-operation: instruction dropped, no wb_valid, regs cleared.
//  - Arithmetic mod 2^8; carry out is the only overflow indication.
// TESTING
//  1 Load r0=0xF0, r1=0x20; ADD r2=r0+r1 -> wb_valid 2 cycles after accept,
//    wb_data 0x10, r2=0x10, carry_flag 1.
//  2 Then ADD usec r3=r1+r1 -> c_in=1, wb_data 0x41, carry_flag 0.
//  3 r0=0x05,r1=0x07 SUB r2=r0-r1 -> 0xFE, carry_flag 0; swap -> 0x02, carry_flag 1.
//  4 r0=0xA5 NOT, r1=0x0F XOR/NAND -> 0x5A, 0xAA, 0xFA; carry_flag unchanged.
//  5 Opcode 1011 -> wb_data 0x00, illegal_op 1, carry_flag unchanged.
//  6 Back-to-back valid held high -> ready 1 only every 3rd cycle; load to dst
//    during WB -> WB value kept; rst during EXEC -> no wb_valid, all regs 0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational alu8. An accepted instruction reaches wb_valid two cycles later.
// One instruction every 3 cycles: instr_ready is high only in IDLE, and the load port is always accepted.
module alu_issue_ctrl #(
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_op,
  input  logic [AW-1:0] instr_dst,
  input  logic [AW-1:0] instr_srca,
  input  logic [AW-1:0] instr_srcb,
  input  logic          instr_usec,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [3:0]    alu_sel,
  output logic          alu_c_in,
  input  logic [7:0]    alu_y,
  input  logic          alu_c,
  output logic          wb_valid,
  output logic [AW-1:0] wb_dst,
  output logic [7:0]    wb_data,
  output logic          carry_flag,
  output logic          illegal_op
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_LAST = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t        state_q, state_d;
  logic [7:0]    regs_q [NREGS];
  logic [7:0]    regs_d [NREGS];
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [7:0]    opa_q, opa_d;
  logic [7:0]    opb_q, opb_d;
  logic          cin_q, cin_d;
  logic [7:0]    res_q, res_d;
  logic          cout_q, cout_d;
  logic          ill_q, ill_d;
  logic          carry_q, carry_d;

  assign instr_ready = (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    op_d    = op_q;
    dst_d   = dst_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cin_d   = cin_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ill_d   = ill_q;
    carry_d = carry_q;

    // Host load first so a same-address writeback below overrides it.
    if (load_en) regs_d[load_addr] = load_data;

    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          state_d = S_EXEC;
          op_d    = instr_op;
          dst_d   = instr_dst;
          opa_d   = regs_q[instr_srca];
          opb_d   = regs_q[instr_srcb];
          cin_d   = instr_usec && (instr_op == OP_ADD) && carry_q;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        ill_d   = (op_q > OP_LAST);
        res_d   = (op_q > OP_LAST) ? 8'h00 : alu_y;
        cout_d  = alu_c;
      end
      S_WB: begin
        state_d        = S_IDLE;
        regs_d[dst_q]  = res_q;
        if ((op_q == OP_ADD) || (op_q == OP_SUB)) carry_d = cout_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
      op_q    <= '0;
      dst_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      cin_q   <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ill_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ill_q   <= ill_d;
      carry_q <= carry_d;
    end
  end

  // Operand registers only change on accept, so the ALU inputs hold between instructions.
  assign alu_a      = opa_q;
  assign alu_b      = opb_q;
  assign alu_sel    = op_q;
  assign alu_c_in   = cin_q;
  assign wb_valid   = (state_q == S_WB);
  assign wb_dst     = dst_q;
  assign wb_data    = res_q;
  assign carry_flag = carry_q;
  assign illegal_op = (state_q == S_WB) && ill_q;

endmodule
